baud_cfg_ctrl: RTL

Configuration sequencer for the shared UART baud_gen divisor. Accepts baud-change requests (table index or raw divisor) over a valid/ready handshake. Quiesces the TX/RX link, holds baud_gen in reset while the divisor (dvsr) is swapped, then releases it and waits for tick to resume before reopening the link. Sits between the host/config logic and the baud_gen + TX/RX pair.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/baud_cfg_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud configuration sequencer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        HOLD,
        SETTLE
    } state_t;

    localparam int DVSR_W   = 11;
    localparam int MIN_DVSR = 2;

    // 100 MHz clock, 16x oversample: dvsr = round(f / (16 * baud)) - 1
    localparam logic [DVSR_W-1:0] BAUD_TABLE [8] = '{
        11'd650,    // 9600
        11'd325,    // 19200
        11'd162,    // 38400
        11'd108,    // 57600
        11'd53,     // 115200
        11'd26,     // 230400
        11'd13,     // 460800
        11'd6       // 921600
    };

endpackage

// File: rtl/baud_cfg_ctrl.sv
// Baud divisor change sequencer: drains the UART link, holds baud_gen in
// reset while dvsr is swapped, then waits for ticks before reopening the link.
//
// state  | meaning
// IDLE   | link open, requests accepted
// DRAIN  | link closed, waiting for tx/rx to finish their frames
// HOLD   | baud_gen held in reset, new divisor presented
// SETTLE | baud_gen running, counting ticks before reopening the link
module baud_cfg_ctrl #(
    parameter int DVSR_W       = uart_pkg::DVSR_W,
    parameter int RESET_SEL    = 0,
    parameter int HOLD_CYCLES  = 4,
    parameter int SETTLE_TICKS = 1,
    parameter int IDLE_TIMEOUT = 65535,
    parameter int MIN_DVSR     = uart_pkg::MIN_DVSR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_raw,
    input  logic [2:0]        cfg_sel,
    input  logic [DVSR_W-1:0] cfg_dvsr,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              tx_busy,
    input  logic              rx_busy,
    input  logic              tick,
    output logic [DVSR_W-1:0] dvsr,
    output logic              bg_rst,
    output logic              link_en
);
    import uart_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TICK_W = $clog2(SETTLE_TICKS + 1);

    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SETTLE_TICKS - 1);
    localparam logic [15:0]       DRAIN_LAST = 16'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);
    localparam logic [DVSR_W-1:0] RESET_DVSR = DVSR_W'(BAUD_TABLE[RESET_SEL]);
    localparam logic [DVSR_W-1:0] MIN_DV     = DVSR_W'(MIN_DVSR);

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [15:0]         drain_cnt, drain_nxt;
    logic [DVSR_W-1:0]   pend_dvsr, pend_nxt;
    logic [DVSR_W-1:0]   dvsr_nxt;
    logic [DVSR_W-1:0]   req_dvsr;
    logic                from_req, req_nxt;
    logic                done_nxt, err_nxt;

    // State, counters and all outputs are registered from the next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD;
            hold_cnt  <= HOLD_INIT;
            tick_cnt  <= '0;
            drain_cnt <= '0;
            pend_dvsr <= RESET_DVSR;
            from_req  <= 1'b0;
            dvsr      <= RESET_DVSR;
            bg_rst    <= 1'b1;
            cfg_ready <= 1'b0;
            link_en   <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            tick_cnt  <= tick_nxt;
            drain_cnt <= drain_nxt;
            pend_dvsr <= pend_nxt;
            from_req  <= req_nxt;
            dvsr      <= dvsr_nxt;
            bg_rst    <= (state_nxt == HOLD);
            cfg_ready <= (state_nxt == IDLE);
            link_en   <= (state_nxt == IDLE);
            cfg_done  <= done_nxt;
            cfg_err   <= err_nxt;
        end
    end

    // Next-state, counter and divisor selection.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        tick_nxt  = tick_cnt;
        drain_nxt = drain_cnt;
        pend_nxt  = pend_dvsr;
        req_nxt   = from_req;
        dvsr_nxt  = dvsr;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        req_dvsr  = cfg_raw ? cfg_dvsr : DVSR_W'(BAUD_TABLE[cfg_sel]);

        unique case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (cfg_raw && (cfg_dvsr < MIN_DV)) begin
                        err_nxt = 1'b1;
                    end else begin
                        pend_nxt  = req_dvsr;
                        drain_nxt = '0;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!tx_busy && !rx_busy) begin
                    dvsr_nxt  = pend_dvsr;
                    hold_nxt  = HOLD_INIT;
                    req_nxt   = 1'b1;
                    state_nxt = HOLD;
                end else if ((IDLE_TIMEOUT != 0) && (drain_cnt >= DRAIN_LAST)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (drain_cnt != 16'hFFFF) begin
                    drain_nxt = drain_cnt + 16'd1;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(1)) begin
                    tick_nxt  = '0;
                    state_nxt = SETTLE;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            SETTLE: begin
                if (tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        done_nxt  = from_req;
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
